// File: rtl/apb_rr_pkg.sv
// Shared types and helpers for the round-robin APB master.
package apb_rr_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETUP  = 2'd1,
    ACCESS = 2'd2
  } apb_state_e;

  // Watchdog counter width; TIMEOUT-1 must fit, so $clog2(TIMEOUT) bits suffice.
  function automatic int wd_width(input int timeout);
    return (timeout > 2) ? $clog2(timeout) : 1;
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin grant: combinational pick starting after last_grant, pointer
// advanced only when the master actually accepts the grant.
module rr_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int IDX_W   = $clog2(NUM_REQ)
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [NUM_REQ-1:0] req,
  input  logic               accept,
  output logic [NUM_REQ-1:0] grant,
  output logic [IDX_W-1:0]   grant_idx,
  output logic               any
);

  logic [IDX_W-1:0] last_grant;
  logic [IDX_W-1:0] cand;

  always_comb begin
    grant     = '0;
    grant_idx = '0;
    any       = 1'b0;
    cand      = '0;
    for (int i = 1; i <= NUM_REQ; i++) begin
      cand = IDX_W'((int'(last_grant) + i) % NUM_REQ);
      if (!any && req[cand]) begin
        any       = 1'b1;
        grant_idx = cand;
      end
    end
    if (any) grant[grant_idx] = 1'b1;
  end

  // Reset points at the highest index so requester 0 wins the first search.
  always_ff @(posedge clk) begin
    if (reset) begin
      last_grant <= IDX_W'(NUM_REQ - 1);
    end else if (accept) begin
      last_grant <= grant_idx;
    end
  end

endmodule

// File: rtl/apb_rr_master.sv
// APB3 master shared by NUM_REQ requesters with round-robin arbitration and a
// watchdog that force-completes transfers to a slave that never asserts ready.
module apb_rr_master
  import apb_rr_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int TIMEOUT = 16
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [NUM_REQ-1:0]        req_valid,
  input  logic [NUM_REQ*ADDR_W-1:0] req_addr,
  input  logic [NUM_REQ-1:0]        req_write,
  input  logic [NUM_REQ*DATA_W-1:0] req_wdata,
  output logic [NUM_REQ-1:0]        req_ready,
  output logic [NUM_REQ-1:0]        rsp_valid,
  output logic [DATA_W-1:0]         rsp_rdata,
  output logic                      rsp_err,
  output logic                      apb_sel,
  output logic                      apb_enable,
  output logic                      apb_write,
  output logic [ADDR_W-1:0]         apb_addr,
  output logic [DATA_W-1:0]         apb_wdata,
  input  logic [DATA_W-1:0]         apb_rdata,
  input  logic                      apb_ready,
  input  logic                      apb_slverr
);

  localparam int IDX_W = $clog2(NUM_REQ);
  localparam int WD_W  = wd_width(TIMEOUT);
  localparam logic [WD_W-1:0] WD_LAST = WD_W'(TIMEOUT - 1);

  apb_state_e state_q, state_d;
  logic [WD_W-1:0]    wd_q, wd_d;
  logic [ADDR_W-1:0]  lat_addr_q, lat_addr_d;
  logic               lat_write_q, lat_write_d;
  logic [DATA_W-1:0]  lat_wdata_q, lat_wdata_d;
  logic [IDX_W-1:0]   lat_idx_q, lat_idx_d;

  logic [NUM_REQ-1:0] req_ready_d, rsp_valid_d;
  logic [DATA_W-1:0]  rsp_rdata_d, wdata_d;
  logic [ADDR_W-1:0]  addr_d;
  logic               rsp_err_d, sel_d, enable_d, write_d;

  logic [NUM_REQ-1:0] arb_grant;
  logic [IDX_W-1:0]   arb_idx;
  logic               arb_any;
  logic               accept;

  logic [ADDR_W-1:0]  addr_arr  [NUM_REQ];
  logic [DATA_W-1:0]  wdata_arr [NUM_REQ];

  always_comb begin
    for (int i = 0; i < NUM_REQ; i++) begin
      addr_arr[i]  = req_addr[i*ADDR_W +: ADDR_W];
      wdata_arr[i] = req_wdata[i*DATA_W +: DATA_W];
    end
  end

  rr_arbiter #(
    .NUM_REQ (NUM_REQ),
    .IDX_W   (IDX_W)
  ) u_arb (
    .clk       (clk),
    .reset     (reset),
    .req       (req_valid),
    .accept    (accept),
    .grant     (arb_grant),
    .grant_idx (arb_idx),
    .any       (arb_any)
  );

  // A grant is taken either in IDLE or on the completing ACCESS edge; the
  // req_ready pulse then marks the one bus-idle cycle before SETUP.
  always_comb begin
    state_d     = state_q;
    wd_d        = wd_q;
    lat_addr_d  = lat_addr_q;
    lat_write_d = lat_write_q;
    lat_wdata_d = lat_wdata_q;
    lat_idx_d   = lat_idx_q;
    req_ready_d = '0;
    rsp_valid_d = '0;
    rsp_rdata_d = rsp_rdata;
    rsp_err_d   = rsp_err;
    sel_d       = apb_sel;
    enable_d    = apb_enable;
    write_d     = apb_write;
    addr_d      = apb_addr;
    wdata_d     = apb_wdata;
    accept      = 1'b0;

    case (state_q)
      IDLE: begin
        if (|req_ready) begin
          state_d  = SETUP;
          sel_d    = 1'b1;
          enable_d = 1'b0;
          addr_d   = lat_addr_q;
          write_d  = lat_write_q;
          wdata_d  = lat_wdata_q;
        end else begin
          accept = arb_any;
        end
      end
      SETUP: begin
        state_d  = ACCESS;
        enable_d = 1'b1;
        wd_d     = '0;
      end
      ACCESS: begin
        if (apb_ready || wd_q == WD_LAST) begin
          state_d                = IDLE;
          sel_d                  = 1'b0;
          enable_d               = 1'b0;
          wd_d                   = '0;
          rsp_valid_d[lat_idx_q] = 1'b1;
          rsp_err_d              = apb_ready ? apb_slverr : 1'b1;
          rsp_rdata_d            = (apb_ready && !lat_write_q) ? apb_rdata : '0;
          accept                 = arb_any;
        end else begin
          wd_d = wd_q + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase

    if (accept) begin
      req_ready_d = arb_grant;
      lat_addr_d  = addr_arr[arb_idx];
      lat_write_d = req_write[arb_idx];
      lat_wdata_d = wdata_arr[arb_idx];
      lat_idx_d   = arb_idx;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      wd_q        <= '0;
      lat_addr_q  <= '0;
      lat_write_q <= 1'b0;
      lat_wdata_q <= '0;
      lat_idx_q   <= '0;
      req_ready   <= '0;
      rsp_valid   <= '0;
      rsp_rdata   <= '0;
      rsp_err     <= 1'b0;
      apb_sel     <= 1'b0;
      apb_enable  <= 1'b0;
      apb_write   <= 1'b0;
      apb_addr    <= '0;
      apb_wdata   <= '0;
    end else begin
      state_q     <= state_d;
      wd_q        <= wd_d;
      lat_addr_q  <= lat_addr_d;
      lat_write_q <= lat_write_d;
      lat_wdata_q <= lat_wdata_d;
      lat_idx_q   <= lat_idx_d;
      req_ready   <= req_ready_d;
      rsp_valid   <= rsp_valid_d;
      rsp_rdata   <= rsp_rdata_d;
      rsp_err     <= rsp_err_d;
      apb_sel     <= sel_d;
      apb_enable  <= enable_d;
      apb_write   <= write_d;
      apb_addr    <= addr_d;
      apb_wdata   <= wdata_d;
    end
  end

endmodule

// File: tb/tb_apb_rr_master.sv
// Directed bench for apb_rr_master: inputs change and outputs are sampled on
// the falling edge, with expected values worked out by hand per cycle.
module tb_apb_rr_master;

  localparam int NUM_REQ = 4;
  localparam int ADDR_W  = 32;
  localparam int DATA_W  = 32;
  localparam int TIMEOUT = 16;

  logic                      clk = 1'b0;
  logic                      reset;
  logic [NUM_REQ-1:0]        req_valid;
  logic [NUM_REQ*ADDR_W-1:0] req_addr;
  logic [NUM_REQ-1:0]        req_write;
  logic [NUM_REQ*DATA_W-1:0] req_wdata;
  logic [NUM_REQ-1:0]        req_ready;
  logic [NUM_REQ-1:0]        rsp_valid;
  logic [DATA_W-1:0]         rsp_rdata;
  logic                      rsp_err;
  logic                      apb_sel;
  logic                      apb_enable;
  logic                      apb_write;
  logic [ADDR_W-1:0]         apb_addr;
  logic [DATA_W-1:0]         apb_wdata;
  logic [DATA_W-1:0]         apb_rdata;
  logic                      apb_ready;
  logic                      apb_slverr;

  int check_count = 0;
  int pass_count  = 0;

  apb_rr_master #(
    .NUM_REQ (NUM_REQ),
    .ADDR_W  (ADDR_W),
    .DATA_W  (DATA_W),
    .TIMEOUT (TIMEOUT)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .req_valid  (req_valid),
    .req_addr   (req_addr),
    .req_write  (req_write),
    .req_wdata  (req_wdata),
    .req_ready  (req_ready),
    .rsp_valid  (rsp_valid),
    .rsp_rdata  (rsp_rdata),
    .rsp_err    (rsp_err),
    .apb_sel    (apb_sel),
    .apb_enable (apb_enable),
    .apb_write  (apb_write),
    .apb_addr   (apb_addr),
    .apb_wdata  (apb_wdata),
    .apb_rdata  (apb_rdata),
    .apb_ready  (apb_ready),
    .apb_slverr (apb_slverr)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [63:0] got, input logic [63:0] exp);
    check_count++;
    if (got === exp) pass_count++;
    else $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  task automatic step();
    @(negedge clk);
  endtask

  task automatic applyStimulus(input int idx, input logic valid, input logic wr,
                               input logic [ADDR_W-1:0] addr, input logic [DATA_W-1:0] wdata);
    req_valid[idx]                 = valid;
    req_write[idx]                 = wr;
    req_addr[idx*ADDR_W +: ADDR_W] = addr;
    req_wdata[idx*DATA_W +: DATA_W] = wdata;
  endtask

  task automatic setSlave(input logic rdy, input logic err, input logic [DATA_W-1:0] rd);
    apb_ready  = rdy;
    apb_slverr = err;
    apb_rdata  = rd;
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL global_timeout: simulation did not finish");
    $fatal(1, "[TB] global timeout");
  end

  initial begin
    int order [6] = '{0, 1, 2, 3, 0, 1};
    int access_cycles;
    int stable;
    logic [NUM_REQ-1:0] onehot;

    reset     = 1'b1;
    req_valid = '0;
    req_addr  = '0;
    req_write = '0;
    req_wdata = '0;
    setSlave(1'b0, 1'b0, '0);
    repeat (3) step();

    checkOutput("rst_req_ready", req_ready, 0);
    checkOutput("rst_rsp_valid", rsp_valid, 0);
    checkOutput("rst_sel_en", {apb_sel, apb_enable}, 0);
    checkOutput("rst_addr", apb_addr, 0);
    checkOutput("rst_rsp", {rsp_err, rsp_rdata}, 0);
    reset = 1'b0;

    // Single read from requester 1, zero wait states.
    applyStimulus(1, 1'b1, 1'b0, 32'h0000_0010, '0);
    setSlave(1'b1, 1'b0, 32'hDEAD_BEEF);
    step();
    checkOutput("rd_req_ready", req_ready, 4'b0010);
    checkOutput("rd_idle_sel", apb_sel, 0);
    applyStimulus(1, 1'b0, 1'b0, 32'h0000_0010, '0);
    step();
    checkOutput("rd_setup", {apb_sel, apb_enable, apb_write}, 3'b100);
    checkOutput("rd_addr", apb_addr, 32'h0000_0010);
    step();
    checkOutput("rd_access", {apb_sel, apb_enable}, 2'b11);
    step();
    checkOutput("rd_rsp_valid", rsp_valid, 4'b0010);
    checkOutput("rd_rdata", rsp_rdata, 32'hDEAD_BEEF);
    checkOutput("rd_err", rsp_err, 0);
    checkOutput("rd_bus_idle", {apb_sel, apb_enable}, 0);
    checkOutput("rd_addr_hold", apb_addr, 32'h0000_0010);

    // Write from requester 2 with three wait states and a slave error.
    applyStimulus(2, 1'b1, 1'b1, 32'h0000_0020, 32'h1234_5678);
    setSlave(1'b0, 1'b1, 32'hAAAA_5555);
    step();
    checkOutput("wr_req_ready", req_ready, 4'b0100);
    applyStimulus(2, 1'b0, 1'b1, 32'h0000_0020, 32'h1234_5678);
    step();
    checkOutput("wr_setup", {apb_sel, apb_enable, apb_write}, 3'b101);
    checkOutput("wr_wdata", apb_wdata, 32'h1234_5678);
    stable = 0;
    for (int i = 0; i < 4; i++) begin
      step();
      if (apb_sel && apb_enable && apb_wdata == 32'h1234_5678 && rsp_valid == 0) stable++;
      if (i == 3) setSlave(1'b1, 1'b1, 32'hAAAA_5555);
    end
    checkOutput("wr_access_stable", stable, 4);
    step();
    checkOutput("wr_rsp_valid", rsp_valid, 4'b0100);
    checkOutput("wr_err", rsp_err, 1);
    checkOutput("wr_rdata", rsp_rdata, 0);

    // Fresh reset, then all requesters hold valid: strict rotation from 0.
    reset = 1'b1;
    setSlave(1'b1, 1'b0, 32'h0000_00A5);
    step();
    reset = 1'b0;
    checkOutput("rr_rst_sel", apb_sel, 0);
    for (int i = 0; i < NUM_REQ; i++) applyStimulus(i, 1'b1, 1'b0, 32'h100 + i*4, '0);
    for (int k = 0; k < 6; k++) begin
      step();
      onehot = 4'(1 << order[k]);
      checkOutput("rr_grant", req_ready, onehot);
      checkOutput("rr_gap_sel", apb_sel, 0);
      if (k > 0) begin
        onehot = 4'(1 << order[k-1]);
        checkOutput("rr_rsp_valid", rsp_valid, onehot);
      end
      if (k == 5) for (int i = 0; i < NUM_REQ; i++) applyStimulus(i, 1'b0, 1'b0, 32'h100 + i*4, '0);
      step();
      checkOutput("rr_setup_addr", apb_addr, 32'h100 + order[k]*4);
      step();
    end
    step();
    checkOutput("rr_last_rsp", rsp_valid, 4'b0010);
    checkOutput("rr_no_grant", req_ready, 0);
    checkOutput("rr_rdata", rsp_rdata, 32'h0000_00A5);

    // Slave never ready: watchdog ends the transfer after 16 ACCESS cycles.
    applyStimulus(3, 1'b1, 1'b0, 32'h0000_0300, '0);
    setSlave(1'b0, 1'b0, 32'hFFFF_FFFF);
    step();
    checkOutput("to_req_ready", req_ready, 4'b1000);
    applyStimulus(3, 1'b0, 1'b0, 32'h0000_0300, '0);
    step();
    access_cycles = 0;
    for (int n = 0; n < 40; n++) begin
      step();
      if (rsp_valid != 0) break;
      if (apb_enable) access_cycles++;
    end
    checkOutput("to_access_cycles", access_cycles, TIMEOUT);
    checkOutput("to_rsp_valid", rsp_valid, 4'b1000);
    checkOutput("to_err", rsp_err, 1);
    checkOutput("to_rdata", rsp_rdata, 0);
    checkOutput("to_bus_idle", {apb_sel, apb_enable}, 0);

    applyStimulus(0, 1'b1, 1'b0, 32'h0000_0040, '0);
    setSlave(1'b1, 1'b0, 32'h0BAD_F00D);
    step();
    checkOutput("after_to_grant", req_ready, 4'b0001);
    applyStimulus(0, 1'b0, 1'b0, 32'h0000_0040, '0);
    repeat (3) step();
    checkOutput("after_to_rsp", rsp_valid, 4'b0001);
    checkOutput("after_to_rdata", rsp_rdata, 32'h0BAD_F00D);
    checkOutput("after_to_err", rsp_err, 0);

    // Ready arrives on the 16th ACCESS cycle: normal completion wins.
    applyStimulus(2, 1'b1, 1'b0, 32'h0000_0050, '0);
    setSlave(1'b0, 1'b0, 32'h5A5A_5A5A);
    step();
    checkOutput("edge_req_ready", req_ready, 4'b0100);
    applyStimulus(2, 1'b0, 1'b0, 32'h0000_0050, '0);
    step();
    access_cycles = 0;
    for (int n = 1; n <= TIMEOUT; n++) begin
      step();
      if (apb_enable && rsp_valid == 0) access_cycles++;
      if (n == TIMEOUT) setSlave(1'b1, 1'b0, 32'h5A5A_5A5A);
    end
    step();
    checkOutput("edge_access_cycles", access_cycles, TIMEOUT);
    checkOutput("edge_rsp_valid", rsp_valid, 4'b0100);
    checkOutput("edge_err", rsp_err, 0);
    checkOutput("edge_rdata", rsp_rdata, 32'h5A5A_5A5A);

    // Reset during ACCESS aborts the transfer and restores priority to 0.
    applyStimulus(1, 1'b1, 1'b0, 32'h0000_0060, '0);
    setSlave(1'b0, 1'b0, '0);
    step();
    checkOutput("abort_req_ready", req_ready, 4'b0010);
    applyStimulus(1, 1'b0, 1'b0, 32'h0000_0060, '0);
    step();
    step();
    checkOutput("abort_in_access", {apb_sel, apb_enable}, 2'b11);
    reset = 1'b1;
    step();
    checkOutput("abort_bus_idle", {apb_sel, apb_enable}, 0);
    checkOutput("abort_no_rsp", rsp_valid, 0);
    reset = 1'b0;
    for (int i = 0; i < NUM_REQ; i++) applyStimulus(i, 1'b1, 1'b0, 32'h200 + i*4, '0);
    setSlave(1'b1, 1'b0, 32'h0000_0077);
    step();
    checkOutput("abort_next_grant", req_ready, 4'b0001);
    for (int i = 0; i < NUM_REQ; i++) applyStimulus(i, 1'b0, 1'b0, 32'h200 + i*4, '0);
    repeat (3) step();
    checkOutput("abort_next_rsp", rsp_valid, 4'b0001);
    checkOutput("abort_next_rdata", rsp_rdata, 32'h0000_0077);

    $display("%0d/%0d checks passed", pass_count, check_count);
    $finish;
  end

endmodule
